// File: rtl/ysyx_24070014_load_store_unit_pkg.sv
// Shared definitions for the load/store unit:
// funct3 width codes, FSM state encoding and bus widths.
package ysyx_24070014_load_store_unit_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/ysyx_24070014_lsu_align.sv
// Combinational lane logic: store strobes/lane data, access checks,
// and load byte/halfword extraction with sign or zero extension.
module ysyx_24070014_lsu_align
    import ysyx_24070014_load_store_unit_pkg::*;
(
    input  logic                i_wen,
    input  logic [2:0]          i_st_funct3,
    input  logic [1:0]          i_st_off,
    input  logic [DATA_LEN-1:0] i_st_wdata,
    output logic [3:0]          o_wstrb,
    output logic [DATA_LEN-1:0] o_wdata,
    output logic                o_misalign,
    output logic                o_illegal,
    input  logic [2:0]          i_ld_funct3,
    input  logic [1:0]          i_ld_off,
    input  logic [DATA_LEN-1:0] i_rdata,
    output logic [DATA_LEN-1:0] o_rdata
);

    logic [DATA_LEN-1:0] w_sh;

    assign w_sh = i_rdata >> {i_ld_off, 3'b000};

    // Store lanes and access legality; reads drive no strobes or data.
    always_comb begin
        o_wstrb    = 4'b0000;
        o_wdata    = '0;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        case (i_st_funct3)
            LB: begin
                if (i_wen) begin
                    o_wstrb = 4'b0001 << i_st_off;
                    o_wdata = {4{i_st_wdata[7:0]}};
                end
            end
            LH: begin
                o_misalign = i_st_off[0];
                if (i_wen) begin
                    o_wstrb = 4'b0011 << i_st_off;
                    o_wdata = {2{i_st_wdata[15:0]}};
                end
            end
            LW: begin
                o_misalign = (i_st_off != 2'b00);
                if (i_wen) begin
                    o_wstrb = 4'b1111;
                    o_wdata = i_st_wdata;
                end
            end
            LBU: o_illegal = i_wen;
            LHU: begin
                o_illegal  = i_wen;
                o_misalign = i_st_off[0];
            end
            default: o_illegal = 1'b1;
        endcase
    end

    // Load extraction from the shifted word, then extension.
    always_comb begin
        o_rdata = '0;
        case (i_ld_funct3)
            LB:      o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
            LH:      o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
            LW:      o_rdata = w_sh;
            LBU:     o_rdata = {24'h0, w_sh[7:0]};
            LHU:     o_rdata = {16'h0, w_sh[15:0]};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24070014_load_store_unit.sv
// Multi-cycle load/store unit between execute and a word-addressed
// valid/ready memory bus; one operation in flight, core stalls meanwhile.
module ysyx_24070014_load_store_unit
    import ysyx_24070014_load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [DATA_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic [ADDR_LEN-1:0] bus_addr,
    output logic                bus_wen,
    output logic [3:0]          bus_wstrb,
    output logic [DATA_LEN-1:0] bus_wdata,
    input  logic                bus_resp_valid,
    input  logic [DATA_LEN-1:0] bus_resp_rdata
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic             TO_EN  = (TIMEOUT_CYCLES != 0);

    lsu_state_e          r_state;
    lsu_state_e          w_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [ADDR_LEN-1:0] r_addr;
    logic [2:0]          r_funct3;
    logic                r_wen;
    logic [3:0]          r_wstrb;
    logic [DATA_LEN-1:0] r_wdata;
    logic [DATA_LEN-1:0] r_rdata;
    logic                r_err;

    logic [3:0]          w_st_wstrb;
    logic [DATA_LEN-1:0] w_st_wdata;
    logic                w_misalign;
    logic                w_illegal;
    logic                w_bad;
    logic [DATA_LEN-1:0] w_ld_data;
    logic                w_accept;
    logic                w_capture;
    logic                w_timeout;
    logic                w_to_hit;

    ysyx_24070014_lsu_align u_align (
        .i_wen       (req_wen),
        .i_st_funct3 (req_funct3),
        .i_st_off    (req_addr[1:0]),
        .i_st_wdata  (req_wdata),
        .o_wstrb     (w_st_wstrb),
        .o_wdata     (w_st_wdata),
        .o_misalign  (w_misalign),
        .o_illegal   (w_illegal),
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_addr[1:0]),
        .i_rdata     (bus_resp_rdata),
        .o_rdata     (w_ld_data)
    );

    assign w_bad     = w_misalign | w_illegal;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_to_hit  = TO_EN && (w_cnt_inc == TO_LIM);

    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = (r_state == S_RESP);
    assign resp_rdata    = r_rdata;
    assign resp_err      = r_err;
    assign bus_req_valid = (r_state == S_REQ);
    assign bus_addr      = {r_addr[ADDR_LEN-1:2], 2'b00};
    assign bus_wen       = r_wen;
    assign bus_wstrb     = r_wstrb;
    assign bus_wdata     = r_wdata;

    // Next state plus accept/capture/timeout strobes for the datapath.
    always_comb begin
        w_nxt     = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_nxt    = w_bad ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    w_capture = bus_resp_valid;
                    w_nxt     = bus_resp_valid ? S_RESP : S_WAIT;
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_nxt     = S_RESP;
                end
            end
            S_WAIT: begin
                if (bus_resp_valid) begin
                    w_capture = 1'b1;
                    w_nxt     = S_RESP;
                end else if (w_to_hit) begin
                    w_timeout = 1'b1;
                    w_nxt     = S_RESP;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    // Timeout counter: restarts on accept and on the bus handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE:  r_cnt <= '0;
                S_REQ:   r_cnt <= bus_req_ready ? '0 : w_cnt_inc;
                S_WAIT:  r_cnt <= w_cnt_inc;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Request fields latched on accept; held stable through REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr   <= '0;
            r_funct3 <= 3'b000;
            r_wen    <= 1'b0;
            r_wstrb  <= 4'b0000;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_wen    <= req_wen;
            r_wstrb  <= w_st_wstrb;
            r_wdata  <= w_st_wdata;
        end
    end

    // Response payload, updated only when entering RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept && w_bad) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end else if (w_capture) begin
            r_rdata <= r_wen ? '0 : w_ld_data;
            r_err   <= 1'b0;
        end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_24070014_load_store_unit.sv
// Directed bench for the load/store unit: vector table with an
// immediately-ready bus, then stall, timeout and reset sequences.
module tb_ysyx_24070014_load_store_unit;
    import ysyx_24070014_load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid2;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        bus_req_ready, bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_req_ready2, bus_resp_valid2;
    logic [31:0] bus_resp_rdata2;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        bus_req_valid, bus_wen;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    logic        req_ready2, resp_valid2, resp_err2;
    logic [31:0] resp_rdata2;
    logic        bus_req_valid2, bus_wen2;
    logic [31:0] bus_addr2, bus_wdata2;
    logic [3:0]  bus_wstrb2;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    ysyx_24070014_load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_wen(bus_wen),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_resp_valid(bus_resp_valid),
        .bus_resp_rdata(bus_resp_rdata)
    );

    ysyx_24070014_load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_wen(req_wen), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
        .resp_err(resp_err2),
        .bus_req_valid(bus_req_valid2), .bus_req_ready(bus_req_ready2),
        .bus_addr(bus_addr2), .bus_wen(bus_wen2),
        .bus_wstrb(bus_wstrb2), .bus_wdata(bus_wdata2),
        .bus_resp_valid(bus_resp_valid2),
        .bus_resp_rdata(bus_resp_rdata2)
    );

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        logic        bus;
        logic [31:0] baddr;
        logic [3:0]  strb;
        logic [31:0] bwd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    localparam int NV = 14;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int nreq;

        v[0]  = '{1'b0, LB,     32'h80000003, 32'h0,        32'h80FF1234,
                  1'b1, 32'h80000000, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0};
        v[1]  = '{1'b0, LBU,    32'h80000003, 32'h0,        32'h80FF1234,
                  1'b1, 32'h80000000, 4'b0000, 32'h0,        32'h00000080, 1'b0};
        v[2]  = '{1'b1, SH,     32'h80000002, 32'h0000ABCD, 32'h0,
                  1'b1, 32'h80000000, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
        v[3]  = '{1'b0, LW,     32'h80000001, 32'h0,        32'h0,
                  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        v[4]  = '{1'b1, 3'b100, 32'h80000000, 32'h000000AA, 32'h0,
                  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        v[5]  = '{1'b0, LH,     32'h80000002, 32'h0,        32'h9ABC0000,
                  1'b1, 32'h80000000, 4'b0000, 32'h0,        32'hFFFF9ABC, 1'b0};
        v[6]  = '{1'b0, LHU,    32'h80000002, 32'h0,        32'h9ABC0000,
                  1'b1, 32'h80000000, 4'b0000, 32'h0,        32'h00009ABC, 1'b0};
        v[7]  = '{1'b1, SB,     32'h80000001, 32'h123456EF, 32'h0,
                  1'b1, 32'h80000000, 4'b0010, 32'hEFEFEFEF, 32'h0,        1'b0};
        v[8]  = '{1'b1, SW,     32'h80000004, 32'hDEADBEEF, 32'h0,
                  1'b1, 32'h80000004, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
        v[9]  = '{1'b0, LW,     32'h80000008, 32'h0,        32'hCAFEF00D,
                  1'b1, 32'h80000008, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0};
        v[10] = '{1'b0, 3'b011, 32'h80000000, 32'h0,        32'h0,
                  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        v[11] = '{1'b1, SH,     32'h80000001, 32'h00001234, 32'h0,
                  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
        v[12] = '{1'b0, LB,     32'h80000001, 32'h0,        32'h00004200,
                  1'b1, 32'h80000000, 4'b0000, 32'h0,        32'h00000042, 1'b0};
        v[13] = '{1'b0, LH,     32'h80000003, 32'h0,        32'h0,
                  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};

        reset = 1'b0;
        req_valid = 1'b0; req_valid2 = 1'b0;
        req_wen = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        bus_resp_rdata = 32'h0;
        bus_req_ready2 = 1'b0; bus_resp_valid2 = 1'b0;
        bus_resp_rdata2 = 32'h0;
        tick; tick;

        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_bus_valid", {31'b0, bus_req_valid}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_wen", {31'b0, bus_wen}, 32'd0);
        chk("rst2_req_ready", {31'b0, req_ready2}, 32'd1);
        reset = 1'b1;
        tick;

        for (int i = 0; i < NV; i++) begin
            req_wen = v[i].wen;
            req_funct3 = v[i].f3;
            req_addr = v[i].addr;
            req_wdata = v[i].wdata;
            req_valid = 1'b1;
            chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'd1);
            tick;
            req_valid = 1'b0;
            if (v[i].bus) begin
                chk($sformatf("v%0d_bus_valid", i),
                    {31'b0, bus_req_valid}, 32'd1);
                chk($sformatf("v%0d_bus_addr", i), bus_addr, v[i].baddr);
                chk($sformatf("v%0d_bus_wen", i),
                    {31'b0, bus_wen}, {31'b0, v[i].wen});
                chk($sformatf("v%0d_bus_wstrb", i),
                    {28'b0, bus_wstrb}, {28'b0, v[i].strb});
                chk($sformatf("v%0d_bus_wdata", i), bus_wdata, v[i].bwd);
                chk($sformatf("v%0d_early_resp", i),
                    {31'b0, resp_valid}, 32'd0);
                bus_req_ready = 1'b1;
                bus_resp_valid = 1'b1;
                bus_resp_rdata = v[i].brd;
                tick;
                bus_req_ready = 1'b0;
                bus_resp_valid = 1'b0;
                bus_resp_rdata = 32'h0;
            end else begin
                chk($sformatf("v%0d_no_bus", i),
                    {31'b0, bus_req_valid}, 32'd0);
            end
            chk($sformatf("v%0d_resp_valid", i),
                {31'b0, resp_valid}, 32'd1);
            chk($sformatf("v%0d_rdata", i), resp_rdata, v[i].rd);
            chk($sformatf("v%0d_err", i),
                {31'b0, resp_err}, {31'b0, v[i].err});
            chk($sformatf("v%0d_busy", i), {31'b0, req_ready}, 32'd0);
            tick;
            chk($sformatf("v%0d_pulse", i), {31'b0, resp_valid}, 32'd0);
            chk($sformatf("v%0d_idle", i), {31'b0, req_ready}, 32'd1);
        end

        // LH with the bus stalled in REQ and then in WAIT.
        req_wen = 1'b0; req_funct3 = LH;
        req_addr = 32'h80000000; req_wdata = 32'h0;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {31'b0, bus_req_valid}, 32'd1);
            chk("stall_addr", bus_addr, 32'h80000000);
            chk("stall_wen", {31'b0, bus_wen}, 32'd0);
            chk("stall_wstrb", {28'b0, bus_wstrb}, 32'h0);
            chk("stall_no_resp", {31'b0, resp_valid}, 32'd0);
            tick;
        end
        bus_req_ready = 1'b1;
        chk("stall_valid_hs", {31'b0, bus_req_valid}, 32'd1);
        tick;
        bus_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("wait_no_req", {31'b0, bus_req_valid}, 32'd0);
            chk("wait_no_resp", {31'b0, resp_valid}, 32'd0);
            tick;
        end
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h00008001;
        tick;
        bus_resp_valid = 1'b0;
        bus_resp_rdata = 32'h0;
        chk("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("stall_rdata", resp_rdata, 32'hFFFF8001);
        chk("stall_err", {31'b0, resp_err}, 32'd0);
        tick;
        chk("stall_idle", {31'b0, req_ready}, 32'd1);
        chk("stall_hold", resp_rdata, 32'hFFFF8001);

        // Timeout in REQ: bus never ready, limit 4.
        req_wen = 1'b0; req_funct3 = LW;
        req_addr = 32'h80000010; req_wdata = 32'h0;
        req_valid2 = 1'b1;
        tick;
        req_valid2 = 1'b0;
        chk("to_bus_addr", bus_addr2, 32'h80000010);
        chk("to_bus_wen", {31'b0, bus_wen2}, 32'd0);
        chk("to_bus_wstrb", {28'b0, bus_wstrb2}, 32'h0);
        chk("to_bus_wdata", bus_wdata2, 32'h0);
        n = 1;
        nreq = 0;
        while (!resp_valid2 && n < 20) begin
            if (bus_req_valid2) nreq++;
            tick;
            n++;
        end
        chk("to_req_cycle", n, 32'd5);
        chk("to_req_count", nreq, 32'd4);
        chk("to_req_drop", {31'b0, bus_req_valid2}, 32'd0);
        chk("to_req_err", {31'b0, resp_err2}, 32'd1);
        chk("to_req_rdata", resp_rdata2, 32'h0);
        tick;
        chk("to_req_idle", {31'b0, req_ready2}, 32'd1);
        chk("to_req_pulse", {31'b0, resp_valid2}, 32'd0);

        // Timeout in WAIT: handshake clears the counter.
        req_valid2 = 1'b1;
        tick;
        req_valid2 = 1'b0;
        bus_req_ready2 = 1'b1;
        tick;
        bus_req_ready2 = 1'b0;
        n = 2;
        while (!resp_valid2 && n < 20) begin
            tick;
            n++;
        end
        chk("to_wait_cycle", n, 32'd6);
        chk("to_wait_err", {31'b0, resp_err2}, 32'd1);
        tick;
        chk("to_wait_idle", {31'b0, req_ready2}, 32'd1);

        // Reset while in WAIT, then a stale bus response.
        req_wen = 1'b0; req_funct3 = LW;
        req_addr = 32'h80000020;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        bus_req_ready = 1'b1;
        tick;
        bus_req_ready = 1'b0;
        chk("rw_in_wait", {31'b0, bus_req_valid | req_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("rw_async_ready", {31'b0, req_ready}, 32'd1);
        chk("rw_async_resp", {31'b0, resp_valid}, 32'd0);
        tick;
        reset = 1'b1;
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 32'h11223344;
        tick;
        bus_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rw_no_resp", {31'b0, resp_valid}, 32'd0);
            chk("rw_ready", {31'b0, req_ready}, 32'd1);
            chk("rw_no_bus", {31'b0, bus_req_valid}, 32'd0);
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/ysyx_24070014_load_store_unit.md
Name: ysyx_24070014_load_store_unit

Overview:
Multi-cycle load/store unit that sits directly downstream of the core's execute stage. It takes the ALU-computed address, store data and funct3, and drives a word-addressed memory bus with a valid/ready handshake and byte strobes. It returns aligned, sign- or zero-extended load data to the writeback mux. It replaces the core's direct combinational memory port, so the core must stall while the unit is busy.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles to wait in REQ or WAIT before aborting with error; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset; reset is asserted when this signal is 0
req_valid  in  1  core presents a memory operation
req_ready  out  1  unit can accept an operation; high only in IDLE
req_wen  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address from ALU
req_wdata  in  32  store data (rs2), LSB-justified
resp_valid  out  1  one-cycle pulse: operation finished
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualified by resp_valid: misaligned, illegal funct3 or timeout
bus_req_valid  out  1  bus request valid
bus_req_ready  in  1  bus accepts the request
bus_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
bus_wen  out  1  write request
bus_wstrb  out  4  byte enables (all 0 for reads)
bus_wdata  out  32  store data shifted into lane position
bus_resp_valid  in  1  read data / write ack valid
bus_resp_rdata  in  32  read word

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset (reset==0, async): state IDLE, timeout counter 0. All outputs 0 except req_ready=1. Reset mid-operation abandons the transaction with no response. Any late bus_resp_valid after reset is ignored.
- IDLE: req_ready=1. On req_valid, register addr, funct3, wen, wdata, and the computed strobe/lane data. Next state is REQ; if the request is misaligned or funct3 illegal, next state is RESP with err=1 and no bus access.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. Illegal funct3: 011, 110, 111 for any operation; 100 or 101 for stores.
- REQ: bus_req_valid=1 with stable addr/wen/wstrb/wdata until bus_req_ready. On handshake go to WAIT and clear the counter. If bus_resp_valid arrives in the same cycle as the handshake, go straight to RESP.
- WAIT: hold until bus_resp_valid, then capture rdata and go to RESP.
- Timeout counter: increments each cycle in REQ and WAIT. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), go to RESP with err=1 and drop bus_req_valid.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in RESP, so there is no back-to-back overlap.
- Best-case latency: request accepted at cycle 0, bus_req_valid at cycle 1, resp_valid at cycle 2 (bus ready and response both at cycle 1). Minimum occupancy is 3 cycles per operation.
- Store lanes: B: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}. H: wstrb=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}. W: wstrb=4'b1111.
- Load extract: byte = rdata>>(8*addr[1:0]); halfword = rdata>>(8*addr[1:0]). B and H sign-extend; BU and HU zero-extend.
- Outputs are registered. resp_rdata and resp_err hold their values until the next RESP and are meaningful only while resp_valid is high.

Decomposition:
- Shared package/definition file: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), FSM state encoding (2-bit), and ADDR_LEN/DATA_LEN of 32.
- One sub-module, ysyx_24070014_lsu_align: purely combinational. It generates store strobe/lane data and misaligned/illegal flags from addr/funct3/wdata, and performs load extraction and extension from rdata/addr/funct3. The top level holds the FSM, counter and registers.

Test Plan:
- LB at 0x80000003, bus returns 0x80FF1234 -> resp_valid with resp_rdata=0xFFFFFF80, err=0. LBU at the same address -> 0x00000080.
- SH at 0x80000002, wdata=0x0000ABCD, bus ready immediately -> bus_addr=0x80000000, wstrb=4'b1100, wdata[31:16]=0xABCD, resp_valid exactly 2 cycles after acceptance.
- LW at 0x80000001 -> bus_req_valid never asserted, resp_valid next cycle with err=1, rdata=0. SB with funct3=100 -> err=1.
- LH at 0x80000000 with bus_req_ready held low for 5 cycles, then response 3 cycles later with 0x00008001 -> bus request fields stable throughout, resp_rdata=0xFFFF8001.
- TIMEOUT_CYCLES=4, bus never responds -> resp_valid with err=1 once the counter reaches 4, then req_ready=1.
- Reset pulled low while in WAIT, then bus_resp_valid pulses after release -> state IDLE, no resp_valid, req_ready=1.
